// File: rtl/mem_interface_pkg.sv
// Shared widths and FSM state encoding for the memory interface stage and its RAM.
package mem_interface_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_CAPT  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_DONE     = 3'd4
  } mem_state_e;

endpackage

// File: rtl/mem_interface.sv
// MAR/MDR holding stage that sequences single-cycle RAM read/write strobes
// and reports completion to the control unit with a one-cycle done pulse.
//
// state       | meaning
// IDLE        | accept MAR/MDR loads and a read or write request
// RD_ISSUE    | ramRead high, RAM registers memory[MAR]
// RD_CAPT     | ramDataOut valid, captured into MDR
// WR_ISSUE    | ramWrite high, RAM stores MDR at MAR
// DONE        | done pulse, MDR holds any read result
module mem_interface
  import mem_interface_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] busIn,
  input  logic              marIn,
  input  logic              mdrIn,
  input  logic              memRead,
  input  logic              memWrite,
  output logic [DATA_W-1:0] mdrOut,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ramAddress,
  output logic              ramRead,
  output logic              ramWrite,
  output logic [DATA_W-1:0] ramDataIn,
  input  logic [DATA_W-1:0] ramDataOut
);

  mem_state_e        state_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (marIn) mar_q <= busIn[ADDR_W-1:0];
          if (mdrIn) mdr_q <= busIn;
          // Write wins over a simultaneous read, matching the RAM's own priority.
          if (memWrite)     state_q <= ST_WR_ISSUE;
          else if (memRead) state_q <= ST_RD_ISSUE;
        end
        ST_RD_ISSUE: state_q <= ST_RD_CAPT;
        ST_RD_CAPT: begin
          mdr_q   <= ramDataOut;
          state_q <= ST_DONE;
        end
        ST_WR_ISSUE: state_q <= ST_DONE;
        ST_DONE:     state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode only the state register, so no input reaches an output combinationally.
  assign ramRead    = (state_q == ST_RD_ISSUE);
  assign ramWrite   = (state_q == ST_WR_ISSUE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign ramAddress = mar_q;
  assign ramDataIn  = mdr_q;
  assign mdrOut     = mdr_q;

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface with a bench-side RAM and a transaction-timeline
// reference model compared every cycle, plus literal spot checks.
module tb_mem_interface;
  import mem_interface_pkg::*;

  localparam int AW = MEM_ADDR_W;
  localparam int DW = MEM_DATA_W;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] busIn = '0;
  logic          marIn = 1'b0, mdrIn = 1'b0, memRead = 1'b0, memWrite = 1'b0;
  logic [DW-1:0] mdrOut, ramDataIn, ramDataOut;
  logic          busy, done, ramRead, ramWrite;
  logic [AW-1:0] ramAddress;

  int n_cmp = 0;
  int n_bad = 0;

  mem_interface dut (
    .clock(clock), .reset(reset), .busIn(busIn), .marIn(marIn), .mdrIn(mdrIn),
    .memRead(memRead), .memWrite(memWrite), .mdrOut(mdrOut), .busy(busy), .done(done),
    .ramAddress(ramAddress), .ramRead(ramRead), .ramWrite(ramWrite),
    .ramDataIn(ramDataIn), .ramDataOut(ramDataOut)
  );

  always #5 clock = ~clock;

  // Bench RAM: synchronous write, registered read.
  logic [DW-1:0] ram_mem [512];
  logic [DW-1:0] ram_rdata = '0;
  assign ramDataOut = ram_rdata;
  initial for (int i = 0; i < 512; i++) ram_mem[i] = 32'hA5A5_0000 | DW'(i);
  always @(posedge clock) begin
    if (ramWrite) ram_mem[ramAddress] <= ramDataIn;
    if (ramRead)  ram_rdata <= ram_mem[ramAddress];
  end

  // Reference model: a transaction is either idle (t==0) or t cycles since acceptance.
  int            m_t = 0;
  bit            m_is_wr = 1'b0;
  logic [AW-1:0] m_mar = '0;
  logic [DW-1:0] m_mdr = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_t = 0; m_is_wr = 1'b0; m_mar = '0; m_mdr = '0;
    end else if (m_t == 0) begin
      if (marIn) m_mar = busIn[AW-1:0];
      if (mdrIn) m_mdr = busIn;
      if (memWrite)     begin m_is_wr = 1'b1; m_t = 1; end
      else if (memRead) begin m_is_wr = 1'b0; m_t = 1; end
    end else begin
      if (!m_is_wr && m_t == 2) m_mdr = ram_mem[m_mar];
      m_t++;
      if ((m_is_wr && m_t > 2) || (!m_is_wr && m_t > 3)) m_t = 0;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare plus strobe counters used by the directed checks.
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  always @(negedge clock) begin
    chk("busy",       DW'(busy),       DW'(m_t != 0));
    chk("ramRead",    DW'(ramRead),    DW'(!m_is_wr && m_t == 1));
    chk("ramWrite",   DW'(ramWrite),   DW'(m_is_wr && m_t == 1));
    chk("done",       DW'(done),       DW'((m_is_wr && m_t == 2) || (!m_is_wr && m_t == 3)));
    chk("ramAddress", DW'(ramAddress), DW'(m_mar));
    chk("mdrOut",     mdrOut,          m_mdr);
    chk("ramDataIn",  ramDataIn,       m_mdr);
    if (ramRead)  rd_cnt++;
    if (ramWrite) wr_cnt++;
    if (done)     done_cnt++;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  // Drive one cycle of inputs, sampled at the next edge, then return them to idle.
  task automatic cyc(input logic [DW-1:0] b, input bit mar, input bit mdr,
                     input bit rd, input bit wr);
    busIn = b; marIn = mar; mdrIn = mdr; memRead = rd; memWrite = wr;
    @(posedge clock); #1;
    busIn = '0; marIn = 0; mdrIn = 0; memRead = 0; memWrite = 0;
  endtask

  int r0, w0, d0;

  initial begin
    idle(3);
    chk("reset busy", DW'(busy), 0);
    chk("reset mdrOut", mdrOut, 0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    // Write DEADBEEF to address 5, then read it back.
    cyc(32'h0000_0005, 1, 0, 0, 0);
    cyc(32'hDEAD_BEEF, 0, 1, 0, 0);
    cyc('0, 0, 0, 0, 1);
    chk("wr strobe", DW'(ramWrite), 1);
    chk("wr addr", DW'(ramAddress), 5);
    idle(1);
    chk("wr done", DW'(done), 1);
    idle(1);
    cyc(32'h0, 0, 1, 0, 0);
    cyc('0, 0, 0, 1, 0);
    chk("rd strobe", DW'(ramRead), 1);
    idle(2);
    chk("rd done", DW'(done), 1);
    chk("rd data", mdrOut, 32'hDEAD_BEEF);
    idle(1);

    // Address wraps modulo 512.
    cyc(32'h0000_0203, 1, 0, 0, 0);
    chk("wrap addr", DW'(ramAddress), 3);
    cyc(32'hCAFE_F00D, 0, 1, 0, 0);
    cyc('0, 0, 0, 0, 1);
    idle(2);
    cyc(32'h0, 0, 1, 0, 0);
    cyc('0, 0, 0, 1, 0);
    idle(2);
    chk("wrap readback", mdrOut, 32'hCAFE_F00D);
    idle(1);

    // Simultaneous read+write: write only.
    cyc(32'h1234_5678, 0, 1, 0, 0);
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
    cyc('0, 0, 0, 1, 1);
    idle(3);
    chk("both rd cnt", DW'(rd_cnt - r0), 0);
    chk("both wr cnt", DW'(wr_cnt - w0), 1);
    chk("both done cnt", DW'(done_cnt - d0), 1);
    chk("both ram word", ram_mem[3], 32'h1234_5678);

    // Requests and loads while busy are ignored.
    cyc(32'h0000_000A, 1, 0, 0, 0);
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
    cyc('0, 0, 0, 1, 0);
    cyc(32'hFFFF_FFFF, 0, 1, 0, 1);
    idle(4);
    chk("busy-ignore data", mdrOut, 32'hA5A5_000A);
    chk("busy-ignore wr cnt", DW'(wr_cnt - w0), 0);
    chk("busy-ignore done cnt", DW'(done_cnt - d0), 1);

    // Reset asserted during RD_CAPT clears everything immediately.
    cyc('0, 0, 0, 1, 0);
    idle(1);
    #2 reset = 1'b1;
    #1;
    chk("rst busy", DW'(busy), 0);
    chk("rst ramRead", DW'(ramRead), 0);
    chk("rst done", DW'(done), 0);
    chk("rst mdr", mdrOut, 0);
    chk("rst mar", DW'(ramAddress), 0);
    @(negedge clock); reset = 1'b0;
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
    idle(5);
    chk("post-rst strobes", DW'((rd_cnt - r0) + (wr_cnt - w0) + (done_cnt - d0)), 0);

    // Same-cycle MAR load and read request use the new address.
    cyc(32'h0000_0007, 1, 0, 1, 0);
    chk("same-cycle rd", DW'(ramRead), 1);
    chk("same-cycle addr", DW'(ramAddress), 7);
    idle(2);
    chk("same-cycle data", mdrOut, 32'hA5A5_0007);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_interface.md
Name: mem_interface

Overview:
Memory-side interface stage between the datapath bus/control unit and the 512x32 synchronous RAM. Holds the MAR (address register) and MDR (data register), and sequences single-cycle ramRead/ramWrite strobes. For reads it captures the RAM's registered output into the MDR one cycle later, then signals completion to the control unit with a one-cycle done pulse.

Parameters:
ADDR_W, 9, RAM address width; MAR width (word-addressed, 512 words)
DATA_W, 32, bus, MDR and RAM data width

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
busIn  input  DATA_W  datapath bus value
marIn  input  1  load MAR from busIn[ADDR_W-1:0] (IDLE only)
mdrIn  input  1  load MDR from busIn (IDLE only)
memRead  input  1  read request, sampled in IDLE
memWrite  input  1  write request, sampled in IDLE
mdrOut  output  DATA_W  current MDR contents, to datapath bus
busy  output  1  high in any non-IDLE state
done  output  1  one-cycle completion pulse
ramAddress  output  ADDR_W  RAM address (= MAR)
ramRead  output  1  RAM read strobe
ramWrite  output  1  RAM write strobe
ramDataIn  output  DATA_W  RAM write data (= MDR)
ramDataOut  input  DATA_W  RAM registered read data

Behaviour:
- Reset (async, any time, incl. mid-transaction): state=IDLE, MAR=0, MDR=0, done=0, busy=0, ramRead=0, ramWrite=0, all immediately; no RAM strobe issued after reset deasserts until a new request.
- States: IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE, DONE.
- ramRead = (state==RD_ISSUE); ramWrite = (state==WR_ISSUE); busy = (state!=IDLE); done = (state==DONE). All decoded from the state register only; no combinational path from any input to any output.
- ramAddress = MAR, ramDataIn = MDR, mdrOut = MDR, continuously.
- IDLE:
  - marIn: MAR <= busIn[ADDR_W-1:0]; upper bus bits ignored (address wraps modulo 512).
  - mdrIn: MDR <= busIn.
  - memWrite=1 -> WR_ISSUE. memRead=1 (memWrite=0) -> RD_ISSUE. Both high: write wins (matches RAM priority), read dropped.
  - Loads and request in the same cycle: the load takes effect at that edge, so the transaction uses the newly loaded MAR/MDR.
- RD_ISSUE (1 cycle): ramRead high; RAM registers memory[MAR] at end of cycle. -> RD_CAPT.
- RD_CAPT (1 cycle): ramDataOut valid; MDR <= ramDataOut at end of cycle. -> DONE.
- WR_ISSUE (1 cycle): ramWrite high; RAM writes MDR to MAR at end of cycle. -> DONE.
- DONE (1 cycle): done=1; MDR holds the read result. -> IDLE.
- Latency, counted from the edge sampling the request: read = done high 3 cycles later (mdrOut valid from that cycle); write = done high 2 cycles later.
- While busy: marIn, mdrIn, memRead and memWrite are ignored (not queued). MAR/MDR stay stable for the whole transaction.
- Back-to-back: a new request may be sampled in the IDLE cycle after DONE. Minimum spacing is 4 cycles for reads and 3 cycles for writes.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults (shared with the RAM) and the state enum encoding (IDLE=0, RD_ISSUE=1, RD_CAPT=2, WR_ISSUE=3, DONE=4, 3-bit).
- Single module, no sub-module. The MAR/MDR registers are simple enough to stay inline; they are not worth a generic register instance.

Test Plan:
- Write then read: marIn with busIn=0x0000_0005, mdrIn with 0xDEAD_BEEF, memWrite -> ramWrite one cycle at address 5, done 2 cycles later. Then memRead -> ramRead one cycle, done 3 cycles later, mdrOut=0xDEAD_BEEF.
- Address wrap: marIn with busIn=0x0000_0203 -> ramAddress=0x003. A subsequent write lands at word 3; readback at MAR=3 returns it.
- Simultaneous memRead+memWrite in IDLE with MDR=0x1234_5678 -> only ramWrite pulses, ramRead never high, a single done after 2 cycles.
- Requests and loads while busy: during a read, pulse memWrite and mdrIn with 0xFFFF_FFFF in RD_ISSUE -> no ramWrite; MDR ends as the RAM read value; exactly one done.
- Reset mid-read: assert reset during RD_CAPT -> ramRead/busy/done=0 and MDR=0 immediately. After release, stays IDLE with no strobes until a new request.
- Same-cycle load+request: marIn with busIn=7 and memRead in one IDLE cycle -> ramRead asserted with ramAddress=7.
